addsub_resp_checker: RTL and testbench
======================================

Name: addsub_resp_checker

Overview:
- Synthesizable response checker for the 32-bit signed adder/subtractor (bit32): the consuming end of its operand/result interface.
- Accepts one transaction per cycle. A transaction is the operands driven into bit32 plus the result and flags bit32 returns in the same cycle.
- Recomputes the golden result, compares it in a 2-stage pipeline, and keeps pass/fail/skip counters and a first-failure capture.
- Used on-chip and in benches in place of waveform inspection.

Parameters:
- W, 32, operand/result width.
- CNT_W, 16, width of each statistics counter; counters saturate.
- STOP_ON_FAIL, 1, when 1, in_ready drops permanently after the first mismatch until clear or reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear of counters, sticky flag, capture and pipeline; rst has priority.
- in_valid  in  1  transaction present.
- in_ready  out  1  checker can accept.
- op_sel  in  2  01 = add, 10 = subtract, 00/11 = no operation.
- op_a  in  W  operand a.
- op_b  in  W  operand b.
- op_cin  in  1  carry-in, used by add only.
- op_bin  in  1  borrow-in, used by subtract only.
- dut_z  in  W  observed result.
- dut_flags  in  6  observed {cout, bout, carry, zero, overflow, negative}.
- chk_valid  out  1  one-cycle pulse: a compare result is available.
- chk_pass  out  1  result of that compare; meaningful only while chk_valid is high.
- fail_sticky  out  1  set by any mismatch.
- pass_cnt  out  CNT_W  passed transactions.
- fail_cnt  out  CNT_W  failed transactions.
- skip_cnt  out  CNT_W  no-operation transactions.
- fail_sel  out  2  captured op_sel of the first failure.
- fail_a  out  W  captured op_a of the first failure.
- fail_b  out  W  captured op_b of the first failure.
- fail_z_exp  out  W  expected result of the first failure.
- fail_z_obs  out  W  observed result of the first failure.
- fail_flags_exp  out  6  expected flags of the first failure.
- fail_flags_obs  out  6  observed flags of the first failure.

Behaviour:
- Reset, and clear: every output register is 0. The pipeline is emptied; in-flight transactions are discarded and never counted.
- in_ready: 1 whenever not (STOP_ON_FAIL and fail_sticky).
- Accept: a transaction is taken when in_valid and in_ready are both high. Operands and DUT outputs are sampled in that same cycle.
- Golden model, add (01):
  - s = a + b + cin, computed at W+1 bits.
  - z = s[W-1:0]; cout = s[W]; bout = 0; carry = cout.
  - overflow = (a[W-1] == b[W-1]) and (z[W-1] != a[W-1]).
- Golden model, subtract (10):
  - z = a - b - bin, modulo 2^W.
  - bout = 1 iff unsigned a < b + bin, with b + bin taken at W+1 bits; cout = 0; carry = bout.
  - overflow = (a[W-1] != b[W-1]) and (z[W-1] != a[W-1]).
- Both operations: zero = (z == 0); negative = z[W-1].
- No-operation (00/11): no compare is made. skip_cnt increments; chk_valid still pulses, with chk_pass = 1.
- Pipeline:
  - Stage 1, registered at accept + 1: expected z/flags, observed z/flags, operands, kind (check or skip).
  - Stage 2, registered at accept + 2: chk_valid, chk_pass, counter update and capture update.
  - Fixed latency: accept in cycle N gives chk_valid in cycle N+2.
- Throughput: back-to-back accepts give back-to-back chk_valid pulses, in order.
- Compare rule: chk_pass = (z_exp == z_obs) and (flags_exp == flags_obs). All 6 flag bits are compared.
- On a mismatch:
  - fail_cnt increments and fail_sticky is set.
  - The capture registers are loaded only if fail_sticky was 0 beforehand, so they hold the first failure only.
- Counters saturate at 2^CNT_W - 1 and do not wrap.
- STOP_ON_FAIL = 1: in_ready falls in the cycle after the failing chk_valid. Transactions accepted before that point still complete and are still counted. Later failures count but do not overwrite the capture.
- clear and an accept in the same cycle: clear wins and the accepted transaction is dropped.
- clear while a stage-2 result is due: no chk_valid pulse is produced.
- clear then deasserted: the checker resumes with in_ready = 1.

Test Plan:
- Add, a=0x7FFFFFFF, b=1, cin=0, dut_z=0x80000000, flags={0,0,0,0,1,1} -> chk_valid at N+2, chk_pass=1, pass_cnt=1.
- Sub, a=0, b=1, bin=0, dut_z=0xFFFFFFFF, flags={0,1,1,0,0,1} -> pass. Then the same stimulus with dut_z=0xFFFFFFFE -> chk_pass=0, fail_cnt=1, fail_z_exp=0xFFFFFFFF, fail_z_obs=0xFFFFFFFE, fail_sticky=1.
- STOP_ON_FAIL=1: 3 back-to-back transactions, the first one bad -> in_ready=0 from the cycle after the first chk_valid. All 3 results are reported; the capture holds transaction 1; the 4th in_valid is not accepted.
- Transactions with op_sel=00 and op_sel=11, carrying arbitrary DUT values -> skip_cnt=2, chk_pass=1, fail_cnt=0.
- CNT_W=2: 5 passing adds -> pass_cnt saturates at 3.
- clear asserted in the same cycle as an accept, with 2 transactions in flight -> no chk_valid pulses, all counters 0, in_ready=1 the next cycle. Repeat with rst in place of clear for an identical result.

Source files
------------

// File: rtl/addsub_resp_checker.sv
// addsub_resp_checker: 2-stage golden-model response checker for the 32-bit signed adder/subtractor
module addsub_resp_checker #(
  parameter int W = 32,
  parameter int CNT_W = 16,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_sel,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic             op_cin,
  input  logic             op_bin,
  input  logic [W-1:0]     dut_z,
  input  logic [5:0]       dut_flags,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic [1:0]       fail_sel,
  output logic [W-1:0]     fail_a,
  output logic [W-1:0]     fail_b,
  output logic [W-1:0]     fail_z_exp,
  output logic [W-1:0]     fail_z_obs,
  output logic [5:0]       fail_flags_exp,
  output logic [5:0]       fail_flags_obs
);
  logic             is_add, is_sub, acc, cout, bout, ovf;
  logic [W:0]       add_s, sub_t;
  logic [W-1:0]     z_g;
  logic [5:0]       f_g;
  logic             s1_vld_q, s1_chk_q, stop_q, match, mis, good, skip;
  logic [W-1:0]     s1_zexp_q, s1_zobs_q, s1_a_q, s1_b_q;
  logic [5:0]       s1_fexp_q, s1_fobs_q;
  logic [1:0]       s1_sel_q;
  logic [CNT_W-1:0] pass_cnt_d, fail_cnt_d, skip_cnt_d;
  // in_ready drops one cycle after the first failing result is reported
  assign in_ready = !(STOP_ON_FAIL && stop_q);
  assign acc = in_valid && in_ready;
  // golden result and flags {cout, bout, carry, zero, overflow, negative}
  always_comb begin
    is_add = op_sel == 2'b01;
    is_sub = op_sel == 2'b10;
    add_s = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin};
    sub_t = {1'b0, op_b} + {{W{1'b0}}, op_bin};
    z_g = is_add ? add_s[W-1:0] : op_a - op_b - {{(W-1){1'b0}}, op_bin};
    cout = is_add && add_s[W];
    bout = is_sub && ({1'b0, op_a} < sub_t);
    ovf = is_add ? (op_a[W-1] == op_b[W-1]) && (z_g[W-1] != op_a[W-1])
                 : (op_a[W-1] != op_b[W-1]) && (z_g[W-1] != op_a[W-1]);
    f_g = {cout, bout, cout | bout, z_g == '0, ovf, z_g[W-1]};
  end
  // stage-2 compare and saturating counter next-state
  always_comb begin
    match = (s1_zexp_q == s1_zobs_q) && (s1_fexp_q == s1_fobs_q);
    good = s1_vld_q && s1_chk_q && match;
    mis = s1_vld_q && s1_chk_q && !match;
    skip = s1_vld_q && !s1_chk_q;
    pass_cnt_d = pass_cnt + {{(CNT_W-1){1'b0}}, good && (pass_cnt != '1)};
    fail_cnt_d = fail_cnt + {{(CNT_W-1){1'b0}}, mis && (fail_cnt != '1)};
    skip_cnt_d = skip_cnt + {{(CNT_W-1){1'b0}}, skip && (skip_cnt != '1)};
  end
  // stage 1 captures golden and observed values; stage 2 reports and counts
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_vld_q <= 1'b0;
      s1_chk_q <= 1'b0;
      s1_zexp_q <= '0;
      s1_zobs_q <= '0;
      s1_fexp_q <= '0;
      s1_fobs_q <= '0;
      s1_sel_q <= '0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      chk_valid <= 1'b0;
      chk_pass <= 1'b0;
      fail_sticky <= 1'b0;
      stop_q <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      skip_cnt <= '0;
    end else begin
      s1_vld_q <= acc;
      s1_chk_q <= is_add || is_sub;
      s1_zexp_q <= z_g;
      s1_zobs_q <= dut_z;
      s1_fexp_q <= f_g;
      s1_fobs_q <= dut_flags;
      s1_sel_q <= op_sel;
      s1_a_q <= op_a;
      s1_b_q <= op_b;
      chk_valid <= s1_vld_q;
      chk_pass <= !s1_chk_q || match;
      fail_sticky <= fail_sticky || mis;
      stop_q <= fail_sticky;
      pass_cnt <= pass_cnt_d;
      fail_cnt <= fail_cnt_d;
      skip_cnt <= skip_cnt_d;
    end
  end
  // first-failure capture, frozen once fail_sticky is set
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fail_sel <= '0;
      fail_a <= '0;
      fail_b <= '0;
      fail_z_exp <= '0;
      fail_z_obs <= '0;
      fail_flags_exp <= '0;
      fail_flags_obs <= '0;
    end else if (mis && !fail_sticky) begin
      fail_sel <= s1_sel_q;
      fail_a <= s1_a_q;
      fail_b <= s1_b_q;
      fail_z_exp <= s1_zexp_q;
      fail_z_obs <= s1_zobs_q;
      fail_flags_exp <= s1_fexp_q;
      fail_flags_obs <= s1_fobs_q;
    end
  end
endmodule

// File: tb/tb_addsub_resp_checker.sv
// tb_addsub_resp_checker: directed-vector bench for the adder/subtractor response checker
module tb_addsub_resp_checker;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, v2 = 0, op_cin = 0, op_bin = 0;
  logic [1:0] op_sel = 0;
  logic [31:0] op_a = 0, op_b = 0, dut_z = 0;
  logic [5:0] dut_flags = 0;
  logic in_ready, chk_valid, chk_pass, fail_sticky;
  logic [15:0] pass_cnt, fail_cnt, skip_cnt;
  logic [1:0] fail_sel;
  logic [31:0] fail_a, fail_b, fail_z_exp, fail_z_obs;
  logic [5:0] fail_flags_exp, fail_flags_obs;
  logic r2, cv2, cp2, fs2;
  logic [1:0] pc2, fc2, sc2, fsel2;
  logic [31:0] fa2, fb2, fze2, fzo2;
  logic [5:0] ffe2, ffo2;
  int vectors = 0, miscompares = 0;
  addsub_resp_checker dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_bin(op_bin),
    .dut_z(dut_z), .dut_flags(dut_flags), .chk_valid(chk_valid), .chk_pass(chk_pass),
    .fail_sticky(fail_sticky), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
    .fail_sel(fail_sel), .fail_a(fail_a), .fail_b(fail_b), .fail_z_exp(fail_z_exp),
    .fail_z_obs(fail_z_obs), .fail_flags_exp(fail_flags_exp), .fail_flags_obs(fail_flags_obs)
  );
  addsub_resp_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(v2), .in_ready(r2),
    .op_sel(op_sel), .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_bin(op_bin),
    .dut_z(dut_z), .dut_flags(dut_flags), .chk_valid(cv2), .chk_pass(cp2),
    .fail_sticky(fs2), .pass_cnt(pc2), .fail_cnt(fc2), .skip_cnt(sc2),
    .fail_sel(fsel2), .fail_a(fa2), .fail_b(fb2), .fail_z_exp(fze2),
    .fail_z_obs(fzo2), .fail_flags_exp(ffe2), .fail_flags_obs(ffo2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                     input logic ci, input logic bi, input logic [31:0] z, input logic [5:0] f);
    op_sel = s; op_a = a; op_b = b; op_cin = ci; op_bin = bi; dut_z = z; dut_flags = f;
    in_valid = 1;
  endtask
  task automatic idle;
    in_valid = 0;
    op_sel = 0;
  endtask
  initial begin
    tick; tick;
    rst = 0;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", chk_valid, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_sticky", fail_sticky, 0);
    // add with signed overflow
    drv(2'b01, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 6'b000011);
    tick; idle;
    chk("add_lat_n1", chk_valid, 0);
    tick;
    chk("add_valid", chk_valid, 1);
    chk("add_pass", chk_pass, 1);
    chk("add_pass_cnt", pass_cnt, 1);
    // add with carry-in wrapping to zero
    drv(2'b01, 32'hFFFFFFFF, 32'h0, 1, 0, 32'h0, 6'b101100);
    tick; idle; tick;
    chk("addz_pass", chk_pass, 1);
    chk("addz_pass_cnt", pass_cnt, 2);
    // subtract with borrow-out
    drv(2'b10, 32'h0, 32'h1, 0, 0, 32'hFFFFFFFF, 6'b011001);
    tick; idle; tick;
    chk("sub_pass", chk_pass, 1);
    chk("sub_pass_cnt", pass_cnt, 3);
    // same subtract with wrong result
    drv(2'b10, 32'h0, 32'h1, 0, 0, 32'hFFFFFFFE, 6'b011001);
    tick; idle; tick;
    chk("subf_valid", chk_valid, 1);
    chk("subf_pass", chk_pass, 0);
    chk("subf_fail_cnt", fail_cnt, 1);
    chk("subf_sticky", fail_sticky, 1);
    chk("subf_z_exp", fail_z_exp, 32'hFFFFFFFF);
    chk("subf_z_obs", fail_z_obs, 32'hFFFFFFFE);
    chk("subf_f_exp", fail_flags_exp, 6'b011001);
    chk("subf_sel", fail_sel, 2'b10);
    chk("subf_ready_same", in_ready, 1);
    tick;
    chk("subf_ready_after", in_ready, 0);
    clear = 1; tick; clear = 0;
    chk("clr_pass_cnt", pass_cnt, 0);
    chk("clr_sticky", fail_sticky, 0);
    chk("clr_ready", in_ready, 1);
    chk("clr_z_exp", fail_z_exp, 0);
    // stop-on-fail: three back-to-back, first and third bad
    drv(2'b01, 32'd1, 32'd2, 0, 0, 32'd4, 6'b0);
    tick;
    drv(2'b01, 32'd5, 32'd6, 0, 0, 32'd11, 6'b0);
    tick;
    drv(2'b10, 32'd10, 32'd3, 0, 0, 32'd8, 6'b0);
    chk("stop_t1_valid", chk_valid, 1);
    chk("stop_t1_pass", chk_pass, 0);
    chk("stop_ready_t3", in_ready, 1);
    tick;
    drv(2'b01, 32'd7, 32'd7, 0, 0, 32'd14, 6'b0);
    chk("stop_ready_low", in_ready, 0);
    chk("stop_t2_valid", chk_valid, 1);
    chk("stop_t2_pass", chk_pass, 1);
    tick; idle;
    chk("stop_t3_valid", chk_valid, 1);
    chk("stop_t3_pass", chk_pass, 0);
    chk("stop_fail_cnt", fail_cnt, 2);
    tick;
    chk("stop_t4_dropped", chk_valid, 0);
    chk("stop_pass_cnt", pass_cnt, 1);
    chk("stop_cap_a", fail_a, 1);
    chk("stop_cap_b", fail_b, 2);
    chk("stop_cap_z_obs", fail_z_obs, 4);
    chk("stop_cap_z_exp", fail_z_exp, 3);
    clear = 1; tick; clear = 0;
    // no-operation selects
    drv(2'b00, 32'h1234, 32'h5678, 1, 1, 32'hDEADBEEF, 6'b111111);
    tick;
    drv(2'b11, 32'hFFFFFFFF, 32'h1, 0, 1, 32'h1234, 6'b010101);
    tick; idle;
    chk("skip1_valid", chk_valid, 1);
    chk("skip1_pass", chk_pass, 1);
    tick;
    chk("skip2_pass", chk_pass, 1);
    chk("skip_cnt", skip_cnt, 2);
    chk("skip_fail_cnt", fail_cnt, 0);
    chk("skip_pass_cnt", pass_cnt, 0);
    tick;
    chk("skip_drained", chk_valid, 0);
    // subtract with borrow-in
    drv(2'b10, 32'd5, 32'd5, 0, 1, 32'hFFFFFFFF, 6'b011001);
    tick; idle; tick;
    chk("subbin_pass", chk_pass, 1);
    chk("subbin_pass_cnt", pass_cnt, 1);
    tick;
    // clear coincident with an accept, one more in flight
    drv(2'b01, 32'd1, 32'd1, 0, 0, 32'd2, 6'b0);
    tick;
    drv(2'b01, 32'd2, 32'd2, 0, 0, 32'd4, 6'b0);
    clear = 1;
    tick; clear = 0; idle;
    chk("clracc_valid1", chk_valid, 0);
    chk("clracc_pass_cnt", pass_cnt, 0);
    chk("clracc_skip_cnt", skip_cnt, 0);
    chk("clracc_ready", in_ready, 1);
    tick;
    chk("clracc_valid2", chk_valid, 0);
    chk("clracc_pass_cnt2", pass_cnt, 0);
    // same with rst
    drv(2'b01, 32'd1, 32'd1, 0, 0, 32'd2, 6'b0);
    tick;
    drv(2'b01, 32'd2, 32'd2, 0, 0, 32'd4, 6'b0);
    rst = 1;
    tick; rst = 0; idle;
    chk("rstacc_valid1", chk_valid, 0);
    chk("rstacc_pass_cnt", pass_cnt, 0);
    chk("rstacc_ready", in_ready, 1);
    tick;
    chk("rstacc_valid2", chk_valid, 0);
    // 2-bit counters saturate
    drv(2'b01, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 6'b000011);
    in_valid = 0; v2 = 1;
    for (int i = 0; i < 5; i++) tick;
    v2 = 0;
    tick; tick;
    chk("sat_pass_cnt", pc2, 3);
    chk("sat_fail_cnt", fc2, 0);
    chk("sat_main_idle", pass_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
